// File: rtl/out_port_alloc_if.sv
// rtl/out_port_alloc_if.sv - request/flit handshake and grant bundle for one output port
interface out_port_alloc_if #(
    parameter int IN_N = 5
);
    localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    logic [IN_N-1:0]  req_i;
    logic [IN_N-1:0]  vld_i;
    logic [IN_N-1:0]  tail_i;
    logic             out_rdy_i;
    logic [SEL_W-1:0] sel_o;
    logic [IN_N-1:0]  gnt_oh_o;
    logic             locked_o;
    logic             xfer_o;
    logic             timeout_o;

    modport master (
        output req_i, vld_i, tail_i, out_rdy_i,
        input  sel_o, gnt_oh_o, locked_o, xfer_o, timeout_o
    );

    modport slave (
        input  req_i, vld_i, tail_i, out_rdy_i,
        output sel_o, gnt_oh_o, locked_o, xfer_o, timeout_o
    );
endinterface

// File: rtl/out_port_alloc.sv
// rtl/out_port_alloc.sv - matrix-arbitrated packet lock for one output port; OUT_PORT_ALLOC_TIMEOUT_EN adds stall release
module out_port_alloc #(
    parameter int IN_N        = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    out_port_alloc_if.slave bus
);
    localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic {IDLE, LOCKED} state_e;
    typedef logic [IN_N-1:0][IN_N-1:0] prio_t;

    // Input 0 beats everyone, input IN_N-1 beats no one.
    function automatic prio_t prio_init();
        prio_t m;
        for (int i = 0; i < IN_N; i++)
            for (int j = 0; j < IN_N; j++)
                m[i][j] = (j > i);
        return m;
    endfunction

    localparam prio_t PRIO_RST = prio_init();

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, win_idx;
    logic [IN_N-1:0]  gnt_q, win_oh, beaten;
    prio_t            prio_q, prio_d;
    logic             sel_vld, xfer, force_rel, do_lock;

    assign sel_vld = bus.vld_i[sel_q];
    assign xfer    = (state_q == LOCKED) && sel_vld && bus.out_rdy_i;
    assign do_lock = (state_q == IDLE) && (|bus.req_i);

    always_comb begin
        beaten  = '0;
        win_oh  = '0;
        win_idx = '0;
        for (int i = 0; i < IN_N; i++) begin
            for (int j = 0; j < IN_N; j++)
                if (j != i && bus.req_i[j] && prio_q[j][i])
                    beaten[i] = 1'b1;
            win_oh[i] = bus.req_i[i] && !beaten[i];
        end
        for (int i = 0; i < IN_N; i++)
            if (win_oh[i])
                win_idx = win_idx | SEL_W'(i);
    end

    // Winner falls to lowest priority: its row cleared, its column set.
    always_comb begin
        prio_d = prio_q;
        if (do_lock) begin
            for (int i = 0; i < IN_N; i++)
                for (int j = 0; j < IN_N; j++) begin
                    if (win_oh[i])
                        prio_d[i][j] = 1'b0;
                    else if (win_oh[j])
                        prio_d[i][j] = 1'b1;
                end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_lock) state_d = LOCKED;
            LOCKED:  if ((xfer && bus.tail_i[sel_q]) || force_rel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            sel_q   <= '0;
            gnt_q   <= '0;
            prio_q  <= PRIO_RST;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            if (do_lock) begin
                sel_q <= win_idx;
                gnt_q <= win_oh;
            end else if (state_d == IDLE) begin
                gnt_q <= '0;
            end
        end
    end

`ifdef OUT_PORT_ALLOC_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] stall_q;
    logic             timeout_q;

    // Only a missing flit counts as a stall; backpressure never forces release.
    assign force_rel = (state_q == LOCKED) && !sel_vld && (stall_q == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (state_q != LOCKED || sel_vld || force_rel)
                stall_q <= '0;
            else
                stall_q <= stall_q + 1'b1;
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    assign force_rel     = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign bus.sel_o    = sel_q;
    assign bus.gnt_oh_o = gnt_q;
    assign bus.locked_o = (state_q == LOCKED);
    assign bus.xfer_o   = xfer;
endmodule

// File: tb/tb_out_port_alloc.sv
// tb/tb_out_port_alloc.sv - directed and random checks of the output port allocator
module tb_out_port_alloc;
    localparam int IN_N = 5;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    out_port_alloc_if #(.IN_N(IN_N)) bus();

    out_port_alloc #(.IN_N(IN_N), .TIMEOUT_CYC(15)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_i = '0; bus.vld_i = '0; bus.tail_i = '0; bus.out_rdy_i = 1'b0;
        @(negedge clk); rst_ni = 1'b0;
        @(negedge clk); rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        bus.req_i = '0; bus.vld_i = '1; bus.tail_i = '1; bus.out_rdy_i = 1'b1;
        rst_ni = 1'b0;
        #3;
        tests++; if (bus.locked_o !== 1'b0) begin fails++; $display("FAIL reset_locked got %b exp 0", bus.locked_o); end
        tests++; if (bus.gnt_oh_o !== 5'b0) begin fails++; $display("FAIL reset_gnt got %b exp 00000", bus.gnt_oh_o); end
        tests++; if (bus.sel_o !== 3'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", bus.sel_o); end
        tests++; if (bus.xfer_o !== 1'b0) begin fails++; $display("FAIL reset_xfer got %b exp 0", bus.xfer_o); end
        tests++; if (bus.timeout_o !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", bus.timeout_o); end
    endtask

    task automatic test_arb_order();
        int exp_sel[4] = '{1, 2, 4, 1};
        logic [IN_N-1:0] exp_gnt;
        do_reset();
        bus.vld_i = '1; bus.tail_i = '1; bus.out_rdy_i = 1'b1; bus.req_i = 5'b10110;
        for (int k = 0; k < 4; k++) begin
            exp_gnt = '0;
            exp_gnt[exp_sel[k]] = 1'b1;
            cyc();
            tests++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'(exp_sel[k]) || bus.gnt_oh_o !== exp_gnt || bus.xfer_o !== 1'b1) begin
                fails++; $display("FAIL arb_lock%0d got lk=%b sel=%0d gnt=%b xf=%b exp lk=1 sel=%0d gnt=%b xf=1", k, bus.locked_o, bus.sel_o, bus.gnt_oh_o, bus.xfer_o, exp_sel[k], exp_gnt);
            end
            cyc();
            tests++; if (bus.locked_o !== 1'b0 || bus.sel_o !== 3'(exp_sel[k]) || bus.gnt_oh_o !== 5'b0 || bus.xfer_o !== 1'b0) begin
                fails++; $display("FAIL arb_idle%0d got lk=%b sel=%0d gnt=%b xf=%b exp lk=0 sel=%0d gnt=00000 xf=0", k, bus.locked_o, bus.sel_o, bus.gnt_oh_o, bus.xfer_o, exp_sel[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_i = 5'b00001; bus.vld_i = 5'b00001; bus.tail_i = 5'b00001; bus.out_rdy_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            tests++; if (bus.locked_o !== 1'((k % 2) == 0) || bus.xfer_o !== 1'((k % 2) == 0)) begin
                fails++; $display("FAIL b2b_cyc%0d got lk=%b xf=%b exp %0d", k, bus.locked_o, bus.xfer_o, (k % 2) == 0);
            end
        end
    endtask

    task automatic test_packet();
        logic rdy_seq[7]  = '{1, 0, 0, 0, 1, 1, 1};
        logic tail_seq[7] = '{0, 0, 0, 0, 0, 0, 1};
        int   nxfer = 0;
        do_reset();
        bus.req_i = 5'b01000; bus.out_rdy_i = 1'b1;
        cyc();
        tests++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'd3) begin fails++; $display("FAIL pkt_lock got lk=%b sel=%0d exp lk=1 sel=3", bus.locked_o, bus.sel_o); end
        bus.req_i = 5'b01001; bus.vld_i = 5'b01001; bus.tail_i = 5'b00001;
        for (int k = 0; k < 7; k++) begin
            bus.out_rdy_i = rdy_seq[k];
            bus.tail_i[3] = tail_seq[k];
            #1;
            if (bus.xfer_o === 1'b1) nxfer++;
            tests++; if (bus.xfer_o !== rdy_seq[k] || bus.locked_o !== 1'b1 || bus.sel_o !== 3'd3) begin
                fails++; $display("FAIL pkt_flit%0d got xf=%b lk=%b sel=%0d exp xf=%b lk=1 sel=3", k, bus.xfer_o, bus.locked_o, bus.sel_o, rdy_seq[k]);
            end
            cyc();
        end
        tests++; if (bus.locked_o !== 1'b0 || bus.gnt_oh_o !== 5'b0) begin fails++; $display("FAIL pkt_release got lk=%b gnt=%b exp lk=0 gnt=00000", bus.locked_o, bus.gnt_oh_o); end
        tests++; if (nxfer !== 4) begin fails++; $display("FAIL pkt_xfer_count got %0d exp 4", nxfer); end
        cyc();
        tests++; if (bus.locked_o !== 1'b1 || bus.sel_o !== 3'd0) begin fails++; $display("FAIL pkt_next got lk=%b sel=%0d exp lk=1 sel=0", bus.locked_o, bus.sel_o); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.vld_i = '1; bus.tail_i = '1; bus.out_rdy_i = 1'b1; bus.req_i = 5'b00010;
        cyc(); cyc();
        bus.req_i = 5'b00100; bus.tail_i = '0;
        cyc();
        tests++; if (bus.sel_o !== 3'd2 || bus.locked_o !== 1'b1) begin fails++; $display("FAIL mid_lock got sel=%0d lk=%b exp sel=2 lk=1", bus.sel_o, bus.locked_o); end
        cyc();
        #2 rst_ni = 1'b0;
        #1;
        tests++; if (bus.locked_o !== 1'b0 || bus.gnt_oh_o !== 5'b0 || bus.sel_o !== 3'd0 || bus.xfer_o !== 1'b0) begin
            fails++; $display("FAIL mid_reset got lk=%b gnt=%b sel=%0d xf=%b exp all 0", bus.locked_o, bus.gnt_oh_o, bus.sel_o, bus.xfer_o);
        end
        @(negedge clk); rst_ni = 1'b1;
        bus.req_i = 5'b00101; bus.tail_i = '1;
        cyc();
        tests++; if (bus.sel_o !== 3'd0 || bus.locked_o !== 1'b1) begin fails++; $display("FAIL mid_regrant got sel=%0d lk=%b exp sel=0 lk=1", bus.sel_o, bus.locked_o); end
        bus.req_i = 5'b01010;
        cyc(); cyc();
        tests++; if (bus.sel_o !== 3'd1 || bus.locked_o !== 1'b1) begin fails++; $display("FAIL mid_matrix got sel=%0d lk=%b exp sel=1 lk=1", bus.sel_o, bus.locked_o); end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.req_i = 5'b10000; bus.out_rdy_i = 1'b1;
        cyc();
        bus.req_i = '0;
        tests++; if (bus.sel_o !== 3'd4 || bus.locked_o !== 1'b1) begin fails++; $display("FAIL to_lock got sel=%0d lk=%b exp sel=4 lk=1", bus.sel_o, bus.locked_o); end
`ifdef OUT_PORT_ALLOC_TIMEOUT_EN
        for (int k = 1; k < 15; k++) begin
            cyc();
            tests++; if (bus.locked_o !== 1'b1 || bus.timeout_o !== 1'b0) begin fails++; $display("FAIL to_hold%0d got lk=%b to=%b exp lk=1 to=0", k, bus.locked_o, bus.timeout_o); end
        end
        cyc();
        tests++; if (bus.locked_o !== 1'b0 || bus.timeout_o !== 1'b1 || bus.gnt_oh_o !== 5'b0) begin
            fails++; $display("FAIL to_fire got lk=%b to=%b gnt=%b exp lk=0 to=1 gnt=00000", bus.locked_o, bus.timeout_o, bus.gnt_oh_o);
        end
        cyc();
        tests++; if (bus.timeout_o !== 1'b0) begin fails++; $display("FAIL to_pulse got %b exp 0", bus.timeout_o); end
        bus.req_i = 5'b10000;
        cyc();
        bus.req_i = '0; bus.vld_i = 5'b10000; bus.out_rdy_i = 1'b0;
        for (int k = 0; k < 20; k++) cyc();
        tests++; if (bus.locked_o !== 1'b1 || bus.timeout_o !== 1'b0) begin fails++; $display("FAIL to_backpressure got lk=%b to=%b exp lk=1 to=0", bus.locked_o, bus.timeout_o); end
`else
        for (int k = 0; k < 20; k++) cyc();
        tests++; if (bus.locked_o !== 1'b1 || bus.timeout_o !== 1'b0) begin fails++; $display("FAIL to_disabled got lk=%b to=%b exp lk=1 to=0", bus.locked_o, bus.timeout_o); end
`endif
    endtask

    task automatic test_random();
        logic [IN_N-1:0] pending = '0;
        logic [IN_N-1:0] exp_gnt;
        int   waits[IN_N] = '{default: 0};
        logic prev_locked = 1'b0;
        int   s;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.req_i = pending;
            bus.vld_i = IN_N'($urandom);
            for (int i = 0; i < IN_N; i++) bus.tail_i[i] = ($urandom_range(0, 3) == 0);
            bus.out_rdy_i = 1'($urandom_range(0, 1));
            cyc();
            exp_gnt = '0;
            if (bus.locked_o === 1'b1) exp_gnt[bus.sel_o] = 1'b1;
            tests++; if (bus.gnt_oh_o !== exp_gnt) begin fails++; $display("FAIL rnd_gnt c=%0d got %b exp %b", c, bus.gnt_oh_o, exp_gnt); end
            if (bus.locked_o === 1'b1 && !prev_locked) begin
                s = int'(bus.sel_o);
                tests++; if (!pending[s]) begin fails++; $display("FAIL rnd_unrequested c=%0d got sel=%0d exp a pending input of %b", c, s, pending); end
                for (int i = 0; i < IN_N; i++) begin
                    if (i != s && pending[i]) begin
                        waits[i]++;
                        tests++; if (waits[i] > IN_N - 1) begin fails++; $display("FAIL rnd_starve c=%0d input %0d got %0d waits exp <= %0d", c, i, waits[i], IN_N - 1); end
                    end
                end
                pending[s] = 1'b0;
                waits[s] = 0;
            end
            prev_locked = bus.locked_o;
            for (int i = 0; i < IN_N; i++) begin
                if (!pending[i] && $urandom_range(0, 2) == 0) begin
                    pending[i] = 1'b1;
                    waits[i] = 0;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_arb_order();
        test_back_to_back();
        test_packet();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
